i2s_clock_controller: RTL
=========================

Name: i2s_clock_controller

Overview:
- Primary-side sequencer for the I2S receiver, which runs in secondary mode. It generates SCK and WS from the 98.304 MHz stream clock.
- Runs continuous stereo frames while enabled. On disable it stops cleanly at a frame boundary, after one flush edge so the receiver emits its last right-channel word.
- Sits between the audio control logic and the receiver's sck/ws inputs, and reports frame timing and alignment status.

Parameters:
- DATA_WIDTH, 32, SCK falling edges per channel slot; frame = 2*DATA_WIDTH falls.
- DIV_WIDTH, 8, width of the SCK half-period setting.
- COUNT_WIDTH, 16, width of the frame counter.

Ports:
- aclk  input  1  clock, 98.304 MHz, same as the receiver's stream clock.
- areset  input  1  asynchronous, active-high reset.
- enable  input  1  level request to run frames.
- half_period  input  DIV_WIDTH  SCK half-period in aclk cycles; 0 treated as 1; latched only when leaving IDLE.
- sck  output  1  registered serial clock to the receiver.
- ws  output  1  registered word select; 0 = left, 1 = right.
- busy  output  1  high when state != IDLE.
- frame_start  output  1  one-cycle pulse on the fall that begins a left slot.
- aligned  output  1  receiver word boundaries are valid from this point on.
- frame_count  output  COUNT_WIDTH  completed frames since reset; wraps.

Behaviour:
- Reset values: sck=0, ws=0, busy=0, frame_start=0, aligned=0, frame_count=0, state=IDLE, all counters 0, latched half-period=1.
- States:
  - IDLE: sck=0, ws=0. When enable=1, latch max(half_period,1), clear div_cnt and bit_cnt, go to RUN.
  - RUN: generates clocks. When enable=0, go to STOP; the current frame keeps running.
  - STOP: clocks continue until the end of the right slot. If enable returns to 1 before that fall, go back to RUN with no gap.
- Divider:
  - div_cnt counts 0..hp-1; at terminal count it wraps to 0 and sck toggles.
  - The first rising edge of sck occurs hp cycles after leaving IDLE; the first falling edge occurs 2*hp cycles after.
  - sck period = 2*hp aclk cycles; hp=16 gives 3.072 MHz SCK and a 48 kHz frame rate.
- Slot counting (on each falling edge of sck, i.e. the aclk cycle in which registered sck goes 1->0):
  - bit_cnt increments modulo DATA_WIDTH; ch toggles when bit_cnt wraps.
  - ws is updated in the same aclk cycle as the fall, so the receiver samples the new value.
  - The first fall of a run begins a left slot with ws=0 and pulses frame_start.
  - After DATA_WIDTH falls, ws goes to 1 (right slot).
  - After another DATA_WIDTH falls, ws goes to 0 and frame_count increments.
    - In RUN: this fall also pulses frame_start and the next frame begins.
    - In STOP: this is the flush fall. sck is forced 0 and the next state is IDLE; no frame_start pulse.
- Idle and flush both leave ws=0. Because the flush leaves the receiver with counter 0 and wsd=0, the next run's first fall loads the MSB correctly.
- aligned:
  - Set on the first 0->1 ws transition after reset.
  - Words emitted by the receiver at that transition or earlier are invalid (its counter is unreset).
  - Sticky until areset.
- Simultaneous events: an enable drop on the same cycle as the frame-end fall in RUN takes effect from that cycle, so that fall is the flush (no frame_start). A half_period change in RUN/STOP is ignored.
- areset mid-frame: outputs go to reset values immediately, with no flush.

Decomposition:
- Package i2s_pkg holds:
  - a typedef enum for the states: IDLE, RUN, STOP;
  - the constants FRAME_FALLS = 2*DATA_WIDTH and HP_48K = 16.
- Sub-module i2s_sck_divider: divider counter, sck register, and a rise/fall strobe output.
- The parent contains the FSM, slot counters, ws, and status.

Test Plan:
- hp=16, DATA_WIDTH=32, enable held high:
  - first fall at cycle 32 after leaving IDLE;
  - 2048 aclk cycles per frame;
  - ws toggles every 1024 cycles;
  - frame_start once per 2048 cycles;
  - frame_count increments each frame.
- enable dropped mid-left-slot:
  - right slot completes, then the flush fall with ws=0;
  - then busy=0 and sck=0, with no further frame_start;
  - a connected i2s_receiver emits a final word with tlast=1.
- enable dropped then restored before the right-slot end: no gap, frame_start at the normal 2048-cycle spacing.
- half_period=0: sck period is 2 aclk cycles. A half_period change from 16 to 8 during RUN is ignored until after IDLE.
- areset asserted mid-frame: all outputs return to 0 immediately. After release plus enable, aligned stays 0 until the first ws rise, then reads 1.
- Loopback with i2s_receiver, sd driving pattern 0xA5A5_0001 left / 0x0000_FFFF right: after aligned=1, words arrive alternating with tlast=0/1 and exact values.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S primary-side clock controller.
package i2s_pkg;

  // Sequencer states; the encoding is also visible on the debug port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  // Default slot width and the number of SCK falls in one stereo frame.
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int FRAME_FALLS        = 2 * DEFAULT_DATA_WIDTH;

  // Half-period giving 3.072 MHz SCK / 48 kHz frames from 98.304 MHz.
  localparam int HP_48K = 16;

endpackage

// File: rtl/i2s_sck_divider.sv
// SCK divider: counts aclk cycles up to the half-period and toggles sck.
// o_toggle is high in the aclk cycle whose closing edge flips sck, so the
// parent can qualify it with the current sck level to find rises/falls.
module i2s_sck_divider #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 i_run,
  input  logic                 i_clear,
  input  logic [DIV_WIDTH-1:0] i_hp,
  output logic                 o_sck,
  output logic                 o_toggle
);

  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic                 r_sck;
  logic                 w_tc;

  // i_hp is never 0 here: the parent saturates it to 1 when latching.
  assign w_tc     = (r_div_cnt == (i_hp - DIV_WIDTH'(1)));
  assign o_toggle = i_run && !i_clear && w_tc;
  assign o_sck    = r_sck;

  // Divider counter and sck register; held at 0 whenever not running.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (!i_run || i_clear) begin
      r_div_cnt <= '0;
      r_sck     <= 1'b0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_sck     <= ~r_sck;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_WIDTH'(1);
    end
  end

endmodule

// File: rtl/i2s_clock_controller.sv
// I2S primary-side sequencer: drives SCK/WS for a secondary-mode receiver,
// runs continuous stereo frames while enabled and stops on a frame boundary
// after one flush fall so the receiver releases its last right-channel word.
module i2s_clock_controller
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DIV_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   enable,
  input  logic [DIV_WIDTH-1:0]   half_period,
  output logic                   sck,
  output logic                   ws,
  output logic                   busy,
  output logic                   frame_start,
  output logic                   aligned,
  output logic [COUNT_WIDTH-1:0] frame_count,
  output state_e                 dbg_state
);

  localparam int              BC_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_WIDTH - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [DIV_WIDTH-1:0]   r_hp;
  logic [BC_W-1:0]        r_bit_cnt;
  logic                   r_ch;
  logic                   r_started;
  logic                   r_ws;
  logic                   r_frame_start;
  logic                   r_aligned;
  logic [COUNT_WIDTH-1:0] r_frame_count;

  logic                   w_leave_idle;
  logic                   w_run;
  logic                   w_sck;
  logic                   w_toggle;
  logic                   w_fall;
  logic                   w_slot_end;
  logic                   w_frame_end;

  assign w_run = (r_state != IDLE);

  i2s_sck_divider #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_div (
    .aclk     (aclk),
    .areset   (areset),
    .i_run    (w_run),
    .i_clear  (w_leave_idle),
    .i_hp     (r_hp),
    .o_sck    (w_sck),
    .o_toggle (w_toggle)
  );

  // A fall is the cycle in which registered sck goes from 1 to 0.
  assign w_fall      = w_toggle && w_sck;
  // The first fall of a run only opens the left slot; slot ends count after it.
  assign w_slot_end  = w_fall && r_started && (r_bit_cnt == BC_LAST);
  assign w_frame_end = w_slot_end && r_ch;

  // Next-state logic. A frame-end fall with enable low is the flush fall,
  // whichever of RUN/STOP we are in, so an enable drop on that very cycle
  // takes effect immediately and no new frame is started.
  always_comb begin
    w_state_next = r_state;
    w_leave_idle = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_next = RUN;
          w_leave_idle = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_next = w_frame_end ? IDLE : STOP;
        end
      end
      STOP: begin
        if (enable) begin
          w_state_next = RUN;
        end else if (w_frame_end) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State register plus the half-period latch taken when a run starts.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state <= IDLE;
      r_hp    <= DIV_WIDTH'(1);
    end else begin
      r_state <= w_state_next;
      if (w_leave_idle) begin
        r_hp <= (half_period == '0) ? DIV_WIDTH'(1) : half_period;
      end
    end
  end

  // Slot counting, ws, frame pulses, frame counter and sticky alignment.
  // ws changes on the same edge as the sck fall so the receiver sees it.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_bit_cnt     <= '0;
      r_ch          <= 1'b0;
      r_started     <= 1'b0;
      r_ws          <= 1'b0;
      r_frame_start <= 1'b0;
      r_aligned     <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_leave_idle) begin
        r_bit_cnt <= '0;
        r_ch      <= 1'b0;
        r_started <= 1'b0;
        r_ws      <= 1'b0;
      end else if (w_fall) begin
        if (!r_started) begin
          r_started     <= 1'b1;
          r_bit_cnt     <= '0;
          r_ch          <= 1'b0;
          r_ws          <= 1'b0;
          r_frame_start <= 1'b1;
        end else if (w_slot_end) begin
          r_bit_cnt <= '0;
          r_ch      <= ~r_ch;
          r_ws      <= ~r_ch;
          if (r_ch) begin
            r_frame_count <= r_frame_count + COUNT_WIDTH'(1);
            r_frame_start <= enable;
          end else begin
            r_aligned <= 1'b1;
          end
        end else begin
          r_bit_cnt <= r_bit_cnt + BC_W'(1);
        end
      end
    end
  end

  assign sck         = w_sck;
  assign ws          = r_ws;
  assign busy        = w_run;
  assign frame_start = r_frame_start;
  assign aligned     = r_aligned;
  assign frame_count = r_frame_count;
  assign dbg_state   = r_state;

endmodule
